// File: rtl/scope_tx_pkg.sv
// Shared types and helpers for the scope UART TX sequencer.
package scope_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RSP,
      ST_HDR,
      ST_SEQ,
      ST_SMP_HI,
      ST_SMP_LO,
      ST_CSUM,
      ST_GAP
   } state_t;

   localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

   typedef struct packed {
      logic [7:0] hi;
      logic [7:0] lo;
   } sample_bytes_t;

   // Samples arrive zero-extended to 16 bits and go out MSB first.
   function automatic sample_bytes_t split_sample(input logic [15:0] s);
      return sample_bytes_t'(s);
   endfunction

endpackage

// File: rtl/tx_byte_slot.sv
// Registered valid/data output slot: loads a new byte or holds until accepted.
module tx_byte_slot (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_data,
   input  logic       tx_ready,
   output logic       tx_valid,
   output logic [7:0] tx_data
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
      end else if (load) begin
         tx_valid <= 1'b1;
         tx_data  <= load_data;
      end else if (tx_ready) begin
         tx_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/scope_tx_sequencer.sv
// Arbitrates the UART TX byte path between ADC sample frames and command responses.
// Define SCOPE_FRAME_SEQ_EN to insert an 8-bit frame sequence number after the header.
module scope_tx_sequencer
   import scope_tx_pkg::*;
#(
   parameter int unsigned SAMPLE_W          = 12,
   parameter int unsigned SAMPLES_PER_FRAME = 64,
   parameter int unsigned FRAME_GAP_CYCLES  = 3744,
   parameter logic [7:0]  HEADER_BYTE       = HEADER_BYTE_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample_data,
   output logic                sample_ready,
   input  logic                rsp_valid,
   input  logic [7:0]          rsp_data,
   output logic                rsp_ready,
   output logic                tx_valid,
   output logic [7:0]          tx_data,
   input  logic                tx_ready,
   output logic                frame_done,
   output logic                busy
);

   localparam int unsigned     GAP_W    = $clog2(FRAME_GAP_CYCLES + 1);
   localparam logic [7:0]       LAST_IDX = 8'(SAMPLES_PER_FRAME - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP_CYCLES - 1);

   state_t           state;
   logic [7:0]       csum;
   logic [7:0]       count;
   logic [GAP_W-1:0] gap_cnt;
   logic             csum_sent;
   logic [7:0]       lo_q;
   sample_bytes_t    cur_bytes;
   logic             slot_free;
   logic             load;
   logic [7:0]       load_data;
`ifdef SCOPE_FRAME_SEQ_EN
   logic [7:0]       seq_num;
`endif

   assign cur_bytes = split_sample(16'(sample_data));
   assign slot_free = !tx_valid || tx_ready;

   // Byte selection for the output slot and the consumer handshakes.
   always_comb begin
      load         = 1'b0;
      load_data    = 8'h00;
      sample_ready = 1'b0;
      rsp_ready    = 1'b0;
      case (state)
         ST_RSP: if (slot_free && rsp_valid) begin
            load      = 1'b1;
            load_data = rsp_data;
            rsp_ready = 1'b1;
         end
         ST_HDR: if (slot_free) begin
            load      = 1'b1;
            load_data = HEADER_BYTE;
         end
`ifdef SCOPE_FRAME_SEQ_EN
         ST_SEQ: if (slot_free) begin
            load      = 1'b1;
            load_data = seq_num;
         end
`endif
         ST_SMP_HI: if (slot_free && sample_valid) begin
            load         = 1'b1;
            load_data    = cur_bytes.hi;
            sample_ready = 1'b1;
         end
         ST_SMP_LO: if (slot_free) begin
            load      = 1'b1;
            load_data = lo_q;
         end
         ST_CSUM: if (slot_free && !csum_sent) begin
            load      = 1'b1;
            load_data = csum;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         csum       <= 8'h00;
         count      <= 8'h00;
         gap_cnt    <= '0;
         csum_sent  <= 1'b0;
         lo_q       <= 8'h00;
`ifdef SCOPE_FRAME_SEQ_EN
         seq_num    <= 8'h00;
`endif
      end else begin
         frame_done <= 1'b0;
         case (state)
            // Frame boundary: a pending response beats the next frame.
            ST_IDLE: begin
               if (rsp_valid) begin
                  state <= ST_RSP;
                  busy  <= 1'b1;
               end else if (enable) begin
                  state <= ST_HDR;
                  busy  <= 1'b1;
               end
            end
            ST_RSP: begin
               if (!rsp_valid || slot_free) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            ST_HDR: begin
               if (slot_free) begin
                  csum  <= 8'h00;
                  count <= 8'h00;
`ifdef SCOPE_FRAME_SEQ_EN
                  state <= ST_SEQ;
`else
                  state <= ST_SMP_HI;
`endif
               end
            end
`ifdef SCOPE_FRAME_SEQ_EN
            ST_SEQ: begin
               if (slot_free) begin
                  csum  <= csum + seq_num;
                  state <= ST_SMP_HI;
               end
            end
`endif
            ST_SMP_HI: begin
               if (slot_free && sample_valid) begin
                  lo_q  <= cur_bytes.lo;
                  csum  <= csum + cur_bytes.hi;
                  state <= ST_SMP_LO;
               end
            end
            ST_SMP_LO: begin
               if (slot_free) begin
                  csum <= csum + lo_q;
                  if (count == LAST_IDX) begin
                     count     <= 8'h00;
                     csum_sent <= 1'b0;
                     state     <= ST_CSUM;
                  end else begin
                     count <= count + 8'd1;
                     state <= ST_SMP_HI;
                  end
               end
            end
            // Checksum is loaded once, then the frame closes when it is accepted.
            ST_CSUM: begin
               if (!csum_sent) begin
                  if (slot_free) csum_sent <= 1'b1;
               end else if (tx_ready) begin
                  csum_sent  <= 1'b0;
                  frame_done <= 1'b1;
                  gap_cnt    <= '0;
                  state      <= ST_GAP;
`ifdef SCOPE_FRAME_SEQ_EN
                  seq_num    <= seq_num + 8'd1;
`endif
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= '0;
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   tx_byte_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (load_data),
      .tx_ready  (tx_ready),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data)
   );

endmodule

// File: tb/tb_scope_tx_sequencer.sv
// Scoreboard bench for scope_tx_sequencer: frame vectors plus response/reset corner cases.
module tb_scope_tx_sequencer;

   localparam int unsigned SW  = 12;
   localparam int unsigned SPF = 2;
   localparam int unsigned GAP = 20;
   localparam logic [7:0]  HDR = 8'hA5;

   typedef struct packed {
      logic [11:0] s0;
      logic [11:0] s1;
      logic        toggle;
      logic [7:0]  h0;
      logic [7:0]  l0;
      logic [7:0]  h1;
      logic [7:0]  l1;
      logic [7:0]  csum;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          sample_valid;
   logic [SW-1:0] sample_data;
   logic          sample_ready;
   logic          rsp_valid;
   logic [7:0]    rsp_data;
   logic          rsp_ready;
   logic          tx_valid;
   logic [7:0]    tx_data;
   logic          tx_ready;
   logic          frame_done;
   logic          busy;

   int         n_chk = 0;
   int         n_fail = 0;
   int         acc_cnt = 0;
   int         done_cnt = 0;
   int         cyc = 0;
   int         acc_cyc = 0;
   int         done_cyc = 0;
   logic       rdy_mode = 1'b0;
   logic [7:0] seq_exp = 8'h00;
   logic [7:0]    exp_q[$];
   logic [SW-1:0] smp_q[$];
   logic [7:0]    rsp_q[$];
   vec_t       vecs[5];

   scope_tx_sequencer #(
      .SAMPLE_W          (SW),
      .SAMPLES_PER_FRAME (SPF),
      .FRAME_GAP_CYCLES  (GAP),
      .HEADER_BYTE       (HDR)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .sample_ready (sample_ready),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_ready    (rsp_ready),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .frame_done   (frame_done),
      .busy         (busy)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every accepted byte pops the next expected one; stalled bytes must hold.
   task automatic monitor();
      logic       stall_prev = 1'b0;
      logic [7:0] stall_data = 8'h00;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check("stall_valid", 32'(tx_valid), 32'd1);
               check("stall_data", 32'(tx_data), 32'(stall_data));
            end
            if (frame_done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (tx_valid && tx_ready) begin
               acc_cnt++;
               acc_cyc = cyc;
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_byte: got %0h expected none", tx_data);
               end else begin
                  check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
               end
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
         end
      end
   endtask

   task automatic smp_feed();
      logic took;
      forever begin
         @(negedge clk);
         took = sample_valid && sample_ready;
         @(posedge clk);
         #2;
         if (took && smp_q.size() > 0) void'(smp_q.pop_front());
         if (smp_q.size() > 0) begin
            sample_valid = 1'b1;
            sample_data  = smp_q[0];
         end else begin
            sample_valid = 1'b0;
         end
      end
   endtask

   task automatic rsp_feed();
      logic took;
      forever begin
         @(negedge clk);
         took = rsp_valid && rsp_ready;
         @(posedge clk);
         #2;
         if (took && rsp_q.size() > 0) void'(rsp_q.pop_front());
         if (rsp_q.size() > 0) begin
            rsp_valid = 1'b1;
            rsp_data  = rsp_q[0];
         end else begin
            rsp_valid = 1'b0;
         end
      end
   endtask

   task automatic rdy_drive();
      forever begin
         @(posedge clk);
         #2;
         tx_ready = rdy_mode ? ~tx_ready : 1'b1;
      end
   endtask

   task automatic wait_accepts(input int n, input int budget, input string name);
      int start = acc_cnt;
      int k = 0;
      while ((acc_cnt - start) < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      check({name, "_accept_timeout"}, 32'((acc_cnt - start) >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while ((exp_q.size() != 0 || busy) && k < budget);
      check({name, "_idle_timeout"}, 32'(exp_q.size() == 0 && !busy), 32'd1);
   endtask

   task automatic push_frame(input vec_t v);
      logic [7:0] c = v.csum;
      exp_q.push_back(HDR);
`ifdef SCOPE_FRAME_SEQ_EN
      exp_q.push_back(seq_exp);
      c = c + seq_exp;
`endif
      exp_q.push_back(v.h0);
      exp_q.push_back(v.l0);
      exp_q.push_back(v.h1);
      exp_q.push_back(v.l1);
      exp_q.push_back(c);
   endtask

   task automatic run_frame(input vec_t v, input string name);
      int d0 = done_cnt;
      rdy_mode = v.toggle;
      push_frame(v);
      smp_q.push_back(v.s0);
      smp_q.push_back(v.s1);
      @(posedge clk);
      #1 enable = 1'b1;
      wait_accepts(1, 200, name);
      #1 enable = 1'b0;
      wait_idle(400, name);
      check({name, "_frame_done"}, 32'(done_cnt - d0), 32'd1);
      seq_exp = seq_exp + 8'd1;
   endtask

   initial begin
      int d0;
      vecs[0] = '{12'h123, 12'h0FF, 1'b0, 8'h01, 8'h23, 8'h00, 8'hFF, 8'h23};
      vecs[1] = '{12'h123, 12'h0FF, 1'b1, 8'h01, 8'h23, 8'h00, 8'hFF, 8'h23};
      vecs[2] = '{12'hFFF, 12'hFFF, 1'b1, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h1C};
      vecs[3] = '{12'h000, 12'h800, 1'b0, 8'h00, 8'h00, 8'h08, 8'h00, 8'h08};
      vecs[4] = '{12'hABC, 12'h001, 1'b1, 8'h0A, 8'hBC, 8'h00, 8'h01, 8'hC7};

      rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_data = '0;
      rsp_valid = 1'b0; rsp_data = 8'h00; tx_ready = 1'b0;
      fork
         monitor();
         smp_feed();
         rsp_feed();
         rdy_drive();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_ready", 32'(rsp_ready), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_tx_valid", 32'(tx_valid), 32'd0);

      for (int i = 0; i < 5; i++) run_frame(vecs[i], "vec");

      // Response arriving mid-frame waits for the frame and its gap.
      rdy_mode = 1'b0;
      d0 = done_cnt;
      push_frame(vecs[0]);
      exp_q.push_back(8'h4B);
      @(posedge clk);
      #1 enable = 1'b1;
      wait_accepts(1, 200, "rsp_mid");
      #1 enable = 1'b0;
      repeat (6) @(posedge clk);
      #1 rsp_q.push_back(8'h4B);
      repeat (10) @(posedge clk);
      check("rsp_held_in_frame", 32'(rsp_q.size()), 32'd1);
      #1;
      smp_q.push_back(vecs[0].s0);
      smp_q.push_back(vecs[0].s1);
      wait_idle(400, "rsp_mid");
      check("rsp_mid_frame_done", 32'(done_cnt - d0), 32'd1);
      check("rsp_after_gap", 32'((acc_cyc - done_cyc) >= int'(GAP)), 32'd1);
      seq_exp = seq_exp + 8'd1;

      // Response and enable together in IDLE: response first.
      rdy_mode = 1'b1;
      d0 = done_cnt;
      exp_q.push_back(8'h3C);
      push_frame(vecs[3]);
      smp_q.push_back(vecs[3].s0);
      smp_q.push_back(vecs[3].s1);
      @(posedge clk);
      #1;
      rsp_q.push_back(8'h3C);
      enable = 1'b1;
      wait_accepts(2, 200, "rsp_first");
      #1 enable = 1'b0;
      wait_idle(400, "rsp_first");
      check("rsp_first_frame_done", 32'(done_cnt - d0), 32'd1);
      seq_exp = seq_exp + 8'd1;

      // Reset mid-frame drops the partial frame.
      rdy_mode = 1'b0;
      push_frame(vecs[4]);
      smp_q.push_back(vecs[4].s0);
      smp_q.push_back(vecs[4].s1);
      @(posedge clk);
      #1 enable = 1'b1;
      wait_accepts(3, 200, "rst_mid");
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      exp_q.delete();
      smp_q.delete();
      enable = 1'b0;
      seq_exp = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      run_frame(vecs[0], "post_rst");

`ifdef SCOPE_FRAME_SEQ_EN
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      seq_exp = 8'h00;
      for (int f = 0; f < 257; f++) run_frame(vecs[f % 5], "seq");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
